alu_step_sequencer: RTL and testbench
=====================================

# alu_step_sequencer

Hardwired control sequencer directly upstream of the `DataPath` block. It replaces bench-driven control with a state machine that generates the per-cycle control strobes for the fetch and execute steps of register-to-register ALU instructions. It sits between the instruction register (IR) output of `DataPath` and every control input of `DataPath`, and handshakes with the top-level run logic through `Run`/`Done`.

## Interface
- `NUM_REGS`, 16, number of general registers; width of the one-hot `Rin`/`Rout` buses.
- `Clock`  in  1  system clock; all state changes on its rising edge.
- `clear`  in  1  synchronous active-low reset: `clear`=0 at a rising edge resets the block.
- `Run`  in  1  start request, sampled in IDLE.
- `IR`  in  32  `DataPath` IR contents; fields: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
- `PCout`, `Zlowout`, `Zhighout`, `MDRout`  out  1 each  bus-drive strobes.
- `MARin`, `PCin`, `MDRin`, `IRin`, `Yin`, `HIin`, `LOin`  out  1 each  register-load strobes.
- `IncPC`, `Read`, `Zin_low`, `Zin_high`  out  1 each  ALU/memory strobes.
- `Rin`, `Rout`  out  16 each  one-hot general-register load/drive selects; at most one bit set.
- `operation`  out  4  ALU function select.
- `Done`  out  1  high during the final step of an instruction.
- `Illegal`  out  1  one-cycle pulse on an unsupported opcode.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6.
- All outputs are decoded from the state register and IR fields; all outputs are 0 in IDLE.
- IDLE -> T0 when `Run`=1; otherwise the block stays in IDLE.
- T0: `PCout`, `MARin`, `IncPC`, `Zin_low`.
- T1: `Zlowout`, `PCin`, `Read`, `MDRin`.
- T2: `MDRout`, `IRin`. `IR` is valid from T3 onward.
- Opcode -> `operation`:
  - add 00011 -> 0000; sub 00100 -> 0001; and 00101 -> 0010; or 00110 -> 0011
  - shr 00111 -> 0100; shl 01000 -> 0101; ror 01001 -> 0110; rol 01010 -> 0111
  - mul 01110 -> 1000; div 01111 -> 1001; neg 10000 -> 1010; not 10001 -> 1011
- Binary class (add..rol):
  - T3: `Rout[Rb]`, `Yin`
  - T4: `Rout[Rc]`, `operation`, `Zin_low`
  - T5: `Zlowout`, `Rin[Ra]`, `Done`
- mul/div:
  - T3: `Rout[Rb]`, `Yin`
  - T4: `Rout[Rc]`, `operation`, `Zin_low`, `Zin_high`
  - T5: `Zlowout`, `LOin`
  - T6: `Zhighout`, `HIin`, `Done`
- Unary class (neg/not):
  - T3: `Rout[Rb]`, `operation`, `Zin_low`
  - T4: `Zlowout`, `Rin[Ra]`, `Done`
- Any other opcode in T3: `Illegal`=1, no other strobes, next state IDLE.
- After a `Done` cycle: next state is T0 if `Run`=1, otherwise IDLE (back-to-back execution).
- `operation` holds 0000 outside the cycles listed above.

## Timing
- One state per clock cycle; no wait states; memory read completes within T1.
- `Run` is sampled only in IDLE and in the `Done` cycle; changes to `Run` in other cycles are ignored.
- Latency from the `Run` sample edge to `Done` high:
  - unary: 5 cycles
  - binary: 6 cycles
  - mul/div: 7 cycles
- Reset: `clear`=0 at any edge, in any state, gives IDLE on the next cycle with all outputs 0. No partial register write occurs after reset.
- `Rin` and `Rout` are never both nonzero in the same cycle. Ra=Rb is legal.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - opcode constants
  - `operation` encodings
  - state enumeration
  - IR field bit positions

  The package is shared with `DataPath`'s ALU.
- One sub-module, `reg_select_decoder`: 4-to-16 one-hot decoder with an enable input. It is instantiated twice, once for `Rin` and once for `Rout`.

## Test plan
- Reset: hold `clear`=0 for 2 cycles mid-T4 -> state IDLE, every output 0, `Rin`=`Rout`=0.
- and R1,R2,R3, `IR`=0x28918000, `Run` pulsed:
  - T3: `Rout`=0x0004, `Yin`=1
  - T4: `Rout`=0x0008, `operation`=0010, `Zin_low`=1
  - T5: `Rin`=0x0002, `Done`=1 (6 cycles after the `Run` sample)
- neg R1,R3, `IR`=0x80980000:
  - T3: `Rout`=0x0008, `operation`=1010, `Zin_low`=1
  - T4: `Rin`=0x0002, `Done`=1
  - T5 and T6 never entered.
- mul R4,R5, `IR`=0x70228000:
  - T4: `Zin_low`=`Zin_high`=1, `operation`=1000
  - T5: `LOin`
  - T6: `HIin` with `Done`; `Rin` stays 0 throughout.
- Illegal opcode, `IR`=0xF8000000 -> `Illegal`=1 for exactly one cycle in T3, then IDLE; no `Rin`, `HIin` or `LOin` asserted.
- `Run` held at 1 across two add instructions -> T0 follows the `Done` cycle immediately, with no IDLE cycle between instructions.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the ALU step sequencer and the DataPath ALU:
// IR field positions, opcodes, ALU function encodings and sequencer states.
package cpu_ctrl_pkg;

    // IR layout
    localparam int IR_W    = 32;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    // Opcodes
    localparam logic [4:0] OPC_ADD = 5'b00011;
    localparam logic [4:0] OPC_SUB = 5'b00100;
    localparam logic [4:0] OPC_AND = 5'b00101;
    localparam logic [4:0] OPC_OR  = 5'b00110;
    localparam logic [4:0] OPC_SHR = 5'b00111;
    localparam logic [4:0] OPC_SHL = 5'b01000;
    localparam logic [4:0] OPC_ROR = 5'b01001;
    localparam logic [4:0] OPC_ROL = 5'b01010;
    localparam logic [4:0] OPC_MUL = 5'b01110;
    localparam logic [4:0] OPC_DIV = 5'b01111;
    localparam logic [4:0] OPC_NEG = 5'b10000;
    localparam logic [4:0] OPC_NOT = 5'b10001;

    // ALU function selects
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SHR = 4'b0100;
    localparam logic [3:0] ALU_SHL = 4'b0101;
    localparam logic [3:0] ALU_ROR = 4'b0110;
    localparam logic [3:0] ALU_ROL = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_DIV = 4'b1001;
    localparam logic [3:0] ALU_NEG = 4'b1010;
    localparam logic [3:0] ALU_NOT = 4'b1011;

    typedef enum logic [2:0] {
        ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6
    } state_t;

    typedef enum logic [1:0] {
        CLS_BINARY, CLS_MULDIV, CLS_UNARY, CLS_ILLEGAL
    } op_class_t;

    // Which execute-step sequence an opcode follows
    function automatic op_class_t opcode_class(input logic [4:0] opc);
        case (opc)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
            OPC_SHR, OPC_SHL, OPC_ROR, OPC_ROL: return CLS_BINARY;
            OPC_MUL, OPC_DIV:                   return CLS_MULDIV;
            OPC_NEG, OPC_NOT:                   return CLS_UNARY;
            default:                            return CLS_ILLEGAL;
        endcase
    endfunction

    // ALU function select for an opcode; unsupported opcodes map to 0000
    function automatic logic [3:0] opcode_alu_op(input logic [4:0] opc);
        case (opc)
            OPC_ADD: return ALU_ADD;
            OPC_SUB: return ALU_SUB;
            OPC_AND: return ALU_AND;
            OPC_OR:  return ALU_OR;
            OPC_SHR: return ALU_SHR;
            OPC_SHL: return ALU_SHL;
            OPC_ROR: return ALU_ROR;
            OPC_ROL: return ALU_ROL;
            OPC_MUL: return ALU_MUL;
            OPC_DIV: return ALU_DIV;
            OPC_NEG: return ALU_NEG;
            OPC_NOT: return ALU_NOT;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-to-N one-hot general-register select decoder; all zeros when disabled.
module reg_select_decoder #(
    parameter int NUM_REGS = 16
) (
    input  logic                i_en,
    input  logic [3:0]          i_sel,
    output logic [NUM_REGS-1:0] o_onehot
);

    // Single bit set at the selected register index only while enabled
    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_step_sequencer.sv
// Hardwired fetch/execute control sequencer for register-to-register ALU
// instructions. Strobes are decoded from the state register and IR fields.
module alu_step_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic                Clock,
    input  logic                clear,
    input  logic                Run,
    input  logic [IR_W-1:0]     IR,
    output logic                PCout,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                MDRout,
    output logic                MARin,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                HIin,
    output logic                LOin,
    output logic                IncPC,
    output logic                Read,
    output logic                Zin_low,
    output logic                Zin_high,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [3:0]          operation,
    output logic                Done,
    output logic                Illegal
);

    state_t    r_state;
    op_class_t w_class;
    logic [4:0] w_opcode;
    logic [3:0] w_ra, w_rb, w_rc;
    logic [3:0] w_alu_op;
    logic [3:0] w_rout_sel;
    logic       w_rin_en, w_rout_en;
    logic       w_unused_ir;

    assign w_opcode    = IR[OPC_MSB:OPC_LSB];
    assign w_ra        = IR[RA_MSB:RA_LSB];
    assign w_rb        = IR[RB_MSB:RB_LSB];
    assign w_rc        = IR[RC_MSB:RC_LSB];
    assign w_class     = opcode_class(w_opcode);
    assign w_alu_op    = opcode_alu_op(w_opcode);
    assign w_unused_ir = ^IR[RC_LSB-1:0];

    // State sequencing; Run is only looked at in IDLE and in the Done step
    always_ff @(posedge Clock) begin
        if (!clear) begin
            r_state <= ST_IDLE;
        end else if (Done) begin
            r_state <= Run ? ST_T0 : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (Run) r_state <= ST_T0;
                ST_T0:   r_state <= ST_T1;
                ST_T1:   r_state <= ST_T2;
                ST_T2:   r_state <= ST_T3;
                ST_T3:   r_state <= (w_class == CLS_ILLEGAL) ? ST_IDLE : ST_T4;
                ST_T4:   r_state <= (w_class == CLS_BINARY || w_class == CLS_MULDIV) ? ST_T5 : ST_IDLE;
                ST_T5:   r_state <= (w_class == CLS_MULDIV) ? ST_T6 : ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Per-step strobe decode; everything idles at zero by default
    always_comb begin
        PCout = 1'b0;  Zlowout = 1'b0;  Zhighout = 1'b0; MDRout = 1'b0;
        MARin = 1'b0;  PCin = 1'b0;     MDRin = 1'b0;    IRin = 1'b0;
        Yin = 1'b0;    HIin = 1'b0;     LOin = 1'b0;     IncPC = 1'b0;
        Read = 1'b0;   Zin_low = 1'b0;  Zin_high = 1'b0;
        operation = 4'b0000;
        Done = 1'b0;   Illegal = 1'b0;
        w_rin_en = 1'b0;
        w_rout_en = 1'b0;
        w_rout_sel = w_rb;
        case (r_state)
            ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin_low = 1'b1; end
            ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            ST_T3: begin
                case (w_class)
                    CLS_BINARY, CLS_MULDIV: begin w_rout_en = 1'b1; Yin = 1'b1; end
                    CLS_UNARY: begin
                        w_rout_en = 1'b1; operation = w_alu_op; Zin_low = 1'b1;
                    end
                    default: Illegal = 1'b1;
                endcase
            end
            ST_T4: begin
                case (w_class)
                    CLS_BINARY, CLS_MULDIV: begin
                        w_rout_en = 1'b1; w_rout_sel = w_rc;
                        operation = w_alu_op; Zin_low = 1'b1;
                        Zin_high = (w_class == CLS_MULDIV);
                    end
                    CLS_UNARY: begin Zlowout = 1'b1; w_rin_en = 1'b1; Done = 1'b1; end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (w_class)
                    CLS_BINARY: begin Zlowout = 1'b1; w_rin_en = 1'b1; Done = 1'b1; end
                    CLS_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
                    default: ;
                endcase
            end
            ST_T6: begin
                if (w_class == CLS_MULDIV) begin
                    Zhighout = 1'b1; HIin = 1'b1; Done = 1'b1;
                end
            end
            default: ;
        endcase
    end

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
        .i_en     (w_rin_en),
        .i_sel    (w_ra),
        .o_onehot (Rin)
    );

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
        .i_en     (w_rout_en),
        .i_sel    (w_rout_sel),
        .o_onehot (Rout)
    );

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Directed bench for alu_step_sequencer: expected per-cycle strobe sets are
// queued when an instruction is launched and compared cycle by cycle.
module tb_alu_step_sequencer;

    logic        Clock, clear, Run;
    logic [31:0] IR;
    logic        PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin;
    logic        Yin, HIin, LOin, IncPC, Read, Zin_low, Zin_high, Done, Illegal;
    logic [15:0] Rin, Rout;
    logic [3:0]  operation;

    alu_step_sequencer #(.NUM_REGS(16)) dut (
        .Clock(Clock), .clear(clear), .Run(Run), .IR(IR),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
        .Zin_low(Zin_low), .Zin_high(Zin_high), .Rin(Rin), .Rout(Rout),
        .operation(operation), .Done(Done), .Illegal(Illegal)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Control strobe bit positions in the packed comparison vector
    localparam logic [16:0] C_PCOUT = 17'h1 << 16, C_ZLOWOUT = 17'h1 << 15,
                            C_ZHIGHOUT = 17'h1 << 14, C_MDROUT = 17'h1 << 13,
                            C_MARIN = 17'h1 << 12, C_PCIN = 17'h1 << 11,
                            C_MDRIN = 17'h1 << 10, C_IRIN = 17'h1 << 9,
                            C_YIN = 17'h1 << 8, C_HIIN = 17'h1 << 7,
                            C_LOIN = 17'h1 << 6, C_INCPC = 17'h1 << 5,
                            C_READ = 17'h1 << 4, C_ZINLOW = 17'h1 << 3,
                            C_ZINHIGH = 17'h1 << 2, C_DONE = 17'h1 << 1,
                            C_ILLEGAL = 17'h1;

    typedef struct {
        string       tag;
        logic [16:0] ctl;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [3:0]  op;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic logic [16:0] obs_ctl();
        return {PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin,
                Yin, HIin, LOin, IncPC, Read, Zin_low, Zin_high, Done, Illegal};
    endfunction

    task automatic push(input string tag, input logic [16:0] ctl,
                        input logic [15:0] rin, input logic [15:0] rout,
                        input logic [3:0] op);
        exp_t e;
        e.tag = tag; e.ctl = ctl; e.rin = rin; e.rout = rout; e.op = op;
        q.push_back(e);
    endtask

    task automatic push_fetch(input string name);
        push({name, "_T0"}, C_PCOUT | C_MARIN | C_INCPC | C_ZINLOW, 16'h0, 16'h0, 4'b0000);
        push({name, "_T1"}, C_ZLOWOUT | C_PCIN | C_READ | C_MDRIN, 16'h0, 16'h0, 4'b0000);
        push({name, "_T2"}, C_MDROUT | C_IRIN, 16'h0, 16'h0, 4'b0000);
    endtask

    task automatic push_idle(input string name);
        push({name, "_idle"}, 17'h0, 16'h0, 16'h0, 4'b0000);
    endtask

    task automatic chk(input string tag, input string field,
                       input logic [16:0] obs, input logic [16:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    // Compare n consecutive cycles against the scoreboard, sampling at negedge
    task automatic consume(input int n);
        exp_t e;
        repeat (n) begin
            @(negedge Clock);
            n_assert++;
            assert (q.size() > 0) else begin
                n_fail++;
                $error("FAIL scoreboard_empty observed=%0d expected=>0", q.size());
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.tag, "ctl", obs_ctl(), e.ctl);
                chk(e.tag, "Rin", {1'b0, Rin}, {1'b0, e.rin});
                chk(e.tag, "Rout", {1'b0, Rout}, {1'b0, e.rout});
                chk(e.tag, "operation", {13'h0, operation}, {13'h0, e.op});
            end
            n_assert++;
            assert (!((|Rin) && (|Rout))) else begin
                n_fail++;
                $error("FAIL rin_rout_exclusive observed=%h/%h expected=one zero", Rin, Rout);
            end
        end
    endtask

    task automatic pulse_run();
        @(negedge Clock);
        Run = 1'b1;
        @(posedge Clock);
        #1 Run = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b0; Run = 1'b0; IR = 32'h0;

        // Power-on reset
        push_idle("por");
        repeat (2) @(posedge Clock);
        consume(1);
        clear = 1'b1;

        // Reset asserted mid-T4 of an and instruction
        IR = 32'h28918000;
        push_fetch("rst");
        push("rst_T3", C_YIN, 16'h0, 16'h0004, 4'b0000);
        push("rst_T4", C_ZINLOW, 16'h0, 16'h0008, 4'b0010);
        push_idle("rst_a"); push_idle("rst_b"); push_idle("rst_c");
        pulse_run();
        consume(5);
        clear = 1'b0;
        consume(2);
        clear = 1'b1;
        consume(1);

        // and R1,R2,R3 ; Done 6 cycles after the Run sample
        IR = 32'h28918000;
        push_fetch("and");
        push("and_T3", C_YIN, 16'h0, 16'h0004, 4'b0000);
        push("and_T4", C_ZINLOW, 16'h0, 16'h0008, 4'b0010);
        push("and_T5", C_ZLOWOUT | C_DONE, 16'h0002, 16'h0, 4'b0000);
        push_idle("and");
        pulse_run();
        consume(7);

        // neg R1,R3 ; T5/T6 never entered
        IR = 32'h80980000;
        push_fetch("neg");
        push("neg_T3", C_ZINLOW, 16'h0, 16'h0008, 4'b1010);
        push("neg_T4", C_ZLOWOUT | C_DONE, 16'h0002, 16'h0, 4'b0000);
        push_idle("neg_a"); push_idle("neg_b");
        pulse_run();
        consume(7);

        // mul R4,R5
        IR = 32'h70228000;
        push_fetch("mul");
        push("mul_T3", C_YIN, 16'h0, 16'h0010, 4'b0000);
        push("mul_T4", C_ZINLOW | C_ZINHIGH, 16'h0, 16'h0020, 4'b1000);
        push("mul_T5", C_ZLOWOUT | C_LOIN, 16'h0, 16'h0, 4'b0000);
        push("mul_T6", C_ZHIGHOUT | C_HIIN | C_DONE, 16'h0, 16'h0, 4'b0000);
        push_idle("mul");
        pulse_run();
        consume(8);

        // Unsupported opcode
        IR = 32'hF8000000;
        push_fetch("ill");
        push("ill_T3", C_ILLEGAL, 16'h0, 16'h0, 4'b0000);
        push_idle("ill_a"); push_idle("ill_b");
        pulse_run();
        consume(6);

        // Two add instructions back-to-back with Run held high
        IR = 32'h18918000;
        push_fetch("b2b1");
        push("b2b1_T3", C_YIN, 16'h0, 16'h0004, 4'b0000);
        push("b2b1_T4", C_ZINLOW, 16'h0, 16'h0008, 4'b0000);
        push("b2b1_T5", C_ZLOWOUT | C_DONE, 16'h0002, 16'h0, 4'b0000);
        push_fetch("b2b2");
        push("b2b2_T3", C_YIN, 16'h0, 16'h0004, 4'b0000);
        push("b2b2_T4", C_ZINLOW, 16'h0, 16'h0008, 4'b0000);
        push("b2b2_T5", C_ZLOWOUT | C_DONE, 16'h0002, 16'h0, 4'b0000);
        push_idle("b2b");
        @(negedge Clock);
        Run = 1'b1;
        consume(9);
        Run = 1'b0;
        consume(4);

        n_assert++;
        assert (q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
